// File: rtl/line_frame_counter.sv
// line_frame_counter: counts new_line pulses against a programmable
// lines-per-frame value, pulses end_frame at each frame boundary, and keeps a
// running frame count. Supports free-running (auto_wrap) and one-shot modes.
// Config loads arriving mid-frame are shadowed and applied at the boundary so
// a frame never changes length while it is being counted.
module line_frame_counter #(
    parameter int LINE_W        = 5,
    parameter int FRAME_W       = 8,
    parameter int DEFAULT_LINES = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enb,
    input  logic               new_line,
    input  logic               restart,
    input  logic               auto_wrap,
    input  logic               cfg_load,
    input  logic [LINE_W-1:0]  cfg_lines,
    output logic [LINE_W-1:0]  line_idx,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic               end_frame,
    output logic               busy,
    output logic               overrun
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [LINE_W-1:0]  LINE_ONE  = LINE_W'(1);
    localparam logic [FRAME_W-1:0] FRAME_ONE = FRAME_W'(1);
    localparam logic [LINE_W-1:0]  LINES_RST = LINE_W'(DEFAULT_LINES);

    state_t             state_q, state_d;
    logic [LINE_W-1:0]  line_idx_q, line_idx_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic               end_frame_q, end_frame_d;
    logic               busy_q, busy_d;
    logic               overrun_q, overrun_d;
    logic [LINE_W-1:0]  lines_q, lines_d;
    logic [LINE_W-1:0]  pend_lines_q, pend_lines_d;
    logic               pend_valid_q, pend_valid_d;

    logic cfg_ok_s;
    logic last_line_s;

    // A zero-length frame is meaningless, so such loads are dropped outright.
    assign cfg_ok_s    = cfg_load && (cfg_lines != {LINE_W{1'b0}});
    // >= rather than == so a stale index can never run past the frame end.
    assign last_line_s = (line_idx_q >= (lines_q - LINE_ONE));

    // Next-state and next-output computation with priority enb > restart > boundary > increment.
    always_comb begin
        state_d      = state_q;
        line_idx_d   = line_idx_q;
        frame_cnt_d  = frame_cnt_q;
        end_frame_d  = 1'b0;
        overrun_d    = overrun_q;
        lines_d      = lines_q;
        pend_lines_d = pend_lines_q;
        pend_valid_d = pend_valid_q;

        if (!enb) begin
            state_d      = ST_IDLE;
            line_idx_d   = {LINE_W{1'b0}};
            frame_cnt_d  = {FRAME_W{1'b0}};
            overrun_d    = 1'b0;
            pend_valid_d = 1'b0;
            if (cfg_ok_s) begin
                lines_d = cfg_lines;
            end else begin
                lines_d = lines_q;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A new_line arriving on the enabling cycle is not counted.
                    state_d = ST_COUNT;
                    if (cfg_ok_s) begin
                        lines_d = cfg_lines;
                    end else begin
                        lines_d = lines_q;
                    end
                end
                ST_COUNT: begin
                    if (restart) begin
                        line_idx_d = {LINE_W{1'b0}};
                        overrun_d  = 1'b0;
                        state_d    = ST_COUNT;
                        if (cfg_ok_s) begin
                            pend_lines_d = cfg_lines;
                            pend_valid_d = 1'b1;
                        end else begin
                            pend_valid_d = pend_valid_q;
                        end
                    end else if (new_line && last_line_s) begin
                        line_idx_d   = {LINE_W{1'b0}};
                        frame_cnt_d  = frame_cnt_q + FRAME_ONE;
                        end_frame_d  = 1'b1;
                        pend_valid_d = 1'b0;
                        // A load coinciding with the boundary is newer than any shadowed one.
                        if (cfg_ok_s) begin
                            lines_d = cfg_lines;
                        end else if (pend_valid_q) begin
                            lines_d = pend_lines_q;
                        end else begin
                            lines_d = lines_q;
                        end
                        if (auto_wrap) begin
                            state_d = ST_COUNT;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        if (new_line) begin
                            line_idx_d = line_idx_q + LINE_ONE;
                        end else begin
                            line_idx_d = line_idx_q;
                        end
                        if (cfg_ok_s) begin
                            pend_lines_d = cfg_lines;
                            pend_valid_d = 1'b1;
                        end else begin
                            pend_valid_d = pend_valid_q;
                        end
                    end
                end
                ST_DONE: begin
                    line_idx_d = {LINE_W{1'b0}};
                    if (cfg_ok_s) begin
                        lines_d = cfg_lines;
                    end else begin
                        lines_d = lines_q;
                    end
                    if (restart) begin
                        overrun_d = 1'b0;
                        state_d   = ST_COUNT;
                    end else if (new_line) begin
                        overrun_d = 1'b1;
                    end else begin
                        overrun_d = overrun_q;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a clean idle.
                    state_d      = ST_IDLE;
                    line_idx_d   = {LINE_W{1'b0}};
                    pend_valid_d = 1'b0;
                end
            endcase
        end

        busy_d = (state_d == ST_COUNT);
    end

    // State, counter, config and registered-output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            line_idx_q   <= {LINE_W{1'b0}};
            frame_cnt_q  <= {FRAME_W{1'b0}};
            end_frame_q  <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            lines_q      <= LINES_RST;
            pend_lines_q <= {LINE_W{1'b0}};
            pend_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            line_idx_q   <= line_idx_d;
            frame_cnt_q  <= frame_cnt_d;
            end_frame_q  <= end_frame_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
            lines_q      <= lines_d;
            pend_lines_q <= pend_lines_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    assign line_idx  = line_idx_q;
    assign frame_cnt = frame_cnt_q;
    assign end_frame = end_frame_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule
